pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage WISC CPU pipeline (IF, ID, EX, MEM, WB). It detects load-use and flag hazards and applies taken-branch redirects in ID. It freezes the pipeline on memory wait states and sequences the halt drain. Its `pc_stall` output is the `stall` signal consumed by the pipeline trace monitor, and `hlt_done` ends simulation.

## Interface
Parameters:
- `REG_W`, default 4: register specifier width.
- `DRAIN_CYCLES`, default 3: cycles for an accepted HLT to travel from EX to WB.
- `PERF_W`, default 32: performance counter width.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset; synchronous, active-low.
- `id_src_a`, `id_src_b`  in  `REG_W` each: source registers of the instruction in ID.
- `id_uses_a`, `id_uses_b`  in  1 each: the ID instruction actually reads that source.
- `id_br_flags`  in  1: ID holds a conditional branch that reads the flags.
- `id_br_taken`  in  1: the ID branch resolves taken this cycle.
- `id_hlt`  in  1: ID holds HLT.
- `ex_dst`  in  `REG_W`: destination register of the instruction in EX.
- `ex_mem_read`, `ex_reg_write`, `ex_sets_flags`  in  1 each: attributes of the EX instruction.
- `mem_busy`  in  1: data/instruction memory wait state.
- `pc_stall`, `if_id_stall`  out  1 each: hold the PC and the IF/ID register.
- `if_id_flush`  out  1: load a NOP into IF/ID.
- `id_ex_flush`  out  1: load a bubble into ID/EX.
- `pipe_freeze`  out  1: hold ID/EX, EX/MEM and MEM/WB.
- `hlt_done`  out  1: HLT has retired from WB.
- `stall_cycles`, `flush_count`  out  `PERF_W` each: performance counters.

## Operation
- **States:** RUN, DRAIN, HALTED. All outputs are combinational from the registered state and the current inputs.
- **Load-use hazard:** `ex_mem_read & ex_reg_write & ex_dst!=0`, and a used source matches `ex_dst`.
- **Flag hazard:** `id_br_flags & ex_sets_flags`.
- **Decision priority in RUN**, highest first:
  - `mem_busy`: `pc_stall=if_id_stall=pipe_freeze=1`. Nothing else acts.
  - Load-use hazard or flag hazard: `pc_stall=if_id_stall=id_ex_flush=1`.
  - `id_br_taken` with no hazard: `if_id_flush=1`. The PC loads the target externally.
  - `id_hlt` with no hazard: accepted. `pc_stall=1`, `if_id_flush=1`, and the next state is DRAIN with the counter at `DRAIN_CYCLES-1`.
- A hazard suppresses the branch flush and HLT acceptance in that cycle. They are re-evaluated on the next cycle.
- **DRAIN:** `pc_stall=1` and `if_id_flush=1` every cycle.
  - The counter decrements each cycle `mem_busy=0`. While `mem_busy=1` it holds and `pipe_freeze=1`.
  - When the counter is 0 and `mem_busy=0`, the next state is HALTED.
- **HALTED:** `pc_stall=if_id_stall=pipe_freeze=1` and `hlt_done=1`, held until reset.
- Hazard inputs are ignored in DRAIN and HALTED.

## Timing
- **Reset values:** state RUN, counter 0, all outputs 0, and both performance counters 0.
- While `rst_n=0`, all outputs are forced to 0 regardless of inputs.
- A reset mid-DRAIN returns to RUN on the next edge.
- A hazard stall lasts exactly 1 cycle per hazard instance. A back-to-back hazard on the next ID instruction yields another stall.
- HLT accepted at edge N puts HLT in EX at N, MEM at N+1 and WB at N+2. The state reaches HALTED at edge N+3, and `hlt_done` is first high in the cycle after edge N+3 when there are no wait states. Each `mem_busy` cycle in DRAIN adds one cycle.
- `mem_busy` asserted simultaneously with a hazard and a taken branch gives freeze only. The flush is never issued while frozen.

## Configuration
- Macro: `PIPE_CTRL_PERF_EN`.
- **Defined:**
  - `stall_cycles` increments, saturating, on every cycle with `pc_stall=1` in RUN or DRAIN.
  - `flush_count` increments, saturating, on every cycle with `if_id_flush=1` or `id_ex_flush=1`. A cycle asserting both counts once.
  - Neither counter increments in HALTED.
- **Undefined:** the counters are not synthesized, the ports remain, and both are tied to 0.

## Structure
- The shared package `pipe_ctrl_pkg` holds:
  - the `pipe_ctrl_state_t` enum (RUN, DRAIN, HALTED);
  - `HLT_DRAIN_CYCLES=3`;
  - a `hazard_t` struct {`load_use`, `flag`}.
- One combinational sub-module, `pipe_hazard_detect`, computes `hazard_t` from the ID/EX fields.
- The FSM, the counter, output decode and the performance counters live in the top.

## Test plan
- **Load-use stall:** EX = LW R3 (`ex_mem_read=1`, `ex_dst=3`); ID reads R3 via A. Expect `pc_stall=if_id_stall=id_ex_flush=1` for 1 cycle, then all 0 once the bubble is in EX.
- **R0 and unused-source exemption:** `ex_dst=0` with a match, or a match on B with `id_uses_b=0`. Expect no stall.
- **Flag hazard, then taken branch:** EX = ADD (`ex_sets_flags=1`); ID = conditional branch, taken. Cycle 1: stall and bubble. Cycle 2: `if_id_flush=1` only.
- **Freeze priority:** `mem_busy=1` for 3 cycles during a load-use hazard plus `id_br_taken`. Expect `pipe_freeze=1` for 3 cycles with no flush, then the hazard stall.
- **Halt drain:** `id_hlt=1` at edge N with no wait states. Expect `hlt_done=1` after edge N+3. With one `mem_busy` cycle inside DRAIN, expect it after edge N+4. Assert reset mid-DRAIN and expect RUN with all outputs 0.
- **Perf counters** (`PIPE_CTRL_PERF_EN` defined): 2 load-use stalls plus 1 taken branch. Expect `stall_cycles=2` and `flush_count=3`. With the macro undefined, both read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pipe_ctrl_state_t;

   // EX -> MEM -> WB travel time of an accepted HLT
   localparam int HLT_DRAIN_CYCLES = 3;

   typedef struct packed {
      logic load_use;
      logic flag;
   } hazard_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use and flag hazard detection between ID and EX
module pipe_hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = 4
) (
   input  logic [REG_W-1:0] id_src_a,
   input  logic [REG_W-1:0] id_src_b,
   input  logic             id_uses_a,
   input  logic             id_uses_b,
   input  logic             id_br_flags,
   input  logic [REG_W-1:0] ex_dst,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic             ex_sets_flags,
   output hazard_t          hazard
);

   logic ex_load_live;
   logic match_a;
   logic match_b;

   // R0 is hardwired, so a load targeting it never produces a usable value to wait for
   assign ex_load_live = ex_mem_read & ex_reg_write & (ex_dst != '0);
   assign match_a      = id_uses_a & (id_src_a == ex_dst);
   assign match_b      = id_uses_b & (id_src_b == ex_dst);

   always_comb begin
      hazard          = '0;
      hazard.load_use = ex_load_live & (match_a | match_b);
      hazard.flag     = id_br_flags & ex_sets_flags;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze controller and HLT drain sequencer; PIPE_CTRL_PERF_EN adds perf counters
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W        = 4,
   parameter int DRAIN_CYCLES = HLT_DRAIN_CYCLES,
   parameter int PERF_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_W-1:0]  id_src_a,
   input  logic [REG_W-1:0]  id_src_b,
   input  logic              id_uses_a,
   input  logic              id_uses_b,
   input  logic              id_br_flags,
   input  logic              id_br_taken,
   input  logic              id_hlt,
   input  logic [REG_W-1:0]  ex_dst,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic              ex_sets_flags,
   input  logic              mem_busy,
   output logic              pc_stall,
   output logic              if_id_stall,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              pipe_freeze,
   output logic              hlt_done,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_count
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   pipe_ctrl_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   hazard_t          hazard;
   logic             any_hazard;

   pipe_hazard_detect #(
      .REG_W (REG_W)
   ) u_detect (
      .id_src_a      (id_src_a),
      .id_src_b      (id_src_b),
      .id_uses_a     (id_uses_a),
      .id_uses_b     (id_uses_b),
      .id_br_flags   (id_br_flags),
      .ex_dst        (ex_dst),
      .ex_mem_read   (ex_mem_read),
      .ex_reg_write  (ex_reg_write),
      .ex_sets_flags (ex_sets_flags),
      .hazard        (hazard)
   );

   assign any_hazard = hazard.load_use | hazard.flag;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_freeze = 1'b0;
      hlt_done    = 1'b0;
      unique case (state_q)
         RUN: begin
            // a wait state freezes everything; flushes would be lost while frozen
            if (mem_busy) begin
               pc_stall    = 1'b1;
               if_id_stall = 1'b1;
               pipe_freeze = 1'b1;
            end else if (any_hazard) begin
               pc_stall    = 1'b1;
               if_id_stall = 1'b1;
               id_ex_flush = 1'b1;
            end else if (id_br_taken) begin
               if_id_flush = 1'b1;
            end else if (id_hlt) begin
               pc_stall    = 1'b1;
               if_id_flush = 1'b1;
               state_d     = DRAIN;
               cnt_d       = DRAIN_LOAD;
            end
         end
         DRAIN: begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            if (mem_busy) begin
               pipe_freeze = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = HALTED;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HALTED: begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            pipe_freeze = 1'b1;
            hlt_done    = 1'b1;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
      if (!rst_n) begin
         pc_stall    = 1'b0;
         if_id_stall = 1'b0;
         if_id_flush = 1'b0;
         id_ex_flush = 1'b0;
         pipe_freeze = 1'b0;
         hlt_done    = 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] stall_q;
   logic [PERF_W-1:0] flush_q;
   logic              count_en;

   assign count_en = (state_q != HALTED);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (count_en && pc_stall && (stall_q != '1)) begin
            stall_q <= stall_q + PERF_W'(1);
         end
         if (count_en && (if_id_flush || id_ex_flush) && (flush_q != '1)) begin
            flush_q <= flush_q + PERF_W'(1);
         end
      end
   end

   assign stall_cycles = rst_n ? stall_q : '0;
   assign flush_count  = rst_n ? flush_q : '0;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench with a rule-level model of the hazard controller
module tb_pipeline_hazard_ctrl;

   localparam int DC = 3;
`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  id_src_a, id_src_b, ex_dst;
   logic        id_uses_a, id_uses_b, id_br_flags, id_br_taken, id_hlt;
   logic        ex_mem_read, ex_reg_write, ex_sets_flags, mem_busy;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, hlt_done;
   logic [31:0] stall_cycles, flush_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_W(4), .DRAIN_CYCLES(DC), .PERF_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_src_a(id_src_a), .id_src_b(id_src_b),
      .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
      .id_br_flags(id_br_flags), .id_br_taken(id_br_taken), .id_hlt(id_hlt),
      .ex_dst(ex_dst), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .ex_sets_flags(ex_sets_flags), .mem_busy(mem_busy),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .hlt_done(hlt_done),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: draining/halted flags plus count of non-busy cycles spent draining
   bit          m_drain = 1'b0;
   bit          m_halt  = 1'b0;
   int          m_seen  = 0;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;

   // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, hlt_done}
   function automatic logic [5:0] expect_out();
      logic lu, fl;
      lu = ex_mem_read && ex_reg_write && (ex_dst != 4'd0) &&
           ((id_uses_a && id_src_a == ex_dst) || (id_uses_b && id_src_b == ex_dst));
      fl = id_br_flags && ex_sets_flags;
      if (!rst_n)      return 6'b000000;
      if (m_halt)      return 6'b110011;
      if (m_drain)     return {4'b1010, mem_busy, 1'b0};
      if (mem_busy)    return 6'b110010;
      if (lu || fl)    return 6'b110100;
      if (id_br_taken) return 6'b001000;
      if (id_hlt)      return 6'b101000;
      return 6'b000000;
   endfunction

   always @(negedge clk) begin
      logic [5:0] e;
      e = expect_out();
      chk("pc_stall",     {31'd0, pc_stall},    {31'd0, e[5]});
      chk("if_id_stall",  {31'd0, if_id_stall}, {31'd0, e[4]});
      chk("if_id_flush",  {31'd0, if_id_flush}, {31'd0, e[3]});
      chk("id_ex_flush",  {31'd0, id_ex_flush}, {31'd0, e[2]});
      chk("pipe_freeze",  {31'd0, pipe_freeze}, {31'd0, e[1]});
      chk("hlt_done",     {31'd0, hlt_done},    {31'd0, e[0]});
      chk("stall_cycles", stall_cycles, rst_n ? m_stall : 32'd0);
      chk("flush_count",  flush_count,  rst_n ? m_flush : 32'd0);
   end

   always @(posedge clk) begin
      logic [5:0] e;
      e = expect_out();
      if (!rst_n) begin
         m_drain = 1'b0; m_halt = 1'b0; m_seen = 0; m_stall = '0; m_flush = '0;
      end else begin
         if (PERF && !m_halt) begin
            if (e[5]) m_stall = m_stall + 1;
            if (e[3] || e[2]) m_flush = m_flush + 1;
         end
         if (m_halt) begin
         end else if (m_drain) begin
            if (!mem_busy) begin
               m_seen++;
               if (m_seen == DC) begin m_drain = 1'b0; m_halt = 1'b1; end
            end
         end else if (e[5] && e[3]) begin
            m_drain = 1'b1;
            m_seen  = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_src_a = 0; id_src_b = 0; id_uses_a = 0; id_uses_b = 0;
      id_br_flags = 0; id_br_taken = 0; id_hlt = 0;
      ex_dst = 0; ex_mem_read = 0; ex_reg_write = 0; ex_sets_flags = 0; mem_busy = 0;
   endtask

   task automatic load_use(input logic [3:0] r);
      ex_mem_read = 1; ex_reg_write = 1; ex_dst = r; id_src_a = r; id_uses_a = 1;
   endtask

   task automatic reset_dut();
      idle();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with hazardous inputs present
      idle();
      rst_n = 0;
      load_use(4'd3);
      id_br_taken = 1;
      @(negedge clk);
      chk("rst_pc_stall", {31'd0, pc_stall}, 32'd0);
      chk("rst_id_ex_flush", {31'd0, id_ex_flush}, 32'd0);
      chk("rst_if_id_flush", {31'd0, if_id_flush}, 32'd0);
      tick(); tick();
      idle(); rst_n = 1;
      @(negedge clk);
      chk("rst_stall_cycles", stall_cycles, 32'd0);
      chk("rst_flush_count", flush_count, 32'd0);

      // load-use: one stall cycle, released when the bubble reaches EX
      tick(); load_use(4'd3);
      @(negedge clk);
      chk("lu_pc_stall", {31'd0, pc_stall}, 32'd1);
      chk("lu_if_id_stall", {31'd0, if_id_stall}, 32'd1);
      chk("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
      tick(); ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0;
      @(negedge clk);
      chk("lu_release", {31'd0, pc_stall}, 32'd0);

      // R0 and unused-source exemptions
      tick(); idle(); ex_mem_read = 1; ex_reg_write = 1; ex_dst = 0; id_uses_a = 1;
      @(negedge clk);
      chk("r0_exempt", {31'd0, pc_stall}, 32'd0);
      tick(); ex_dst = 5; id_src_a = 1; id_src_b = 5; id_uses_b = 0;
      @(negedge clk);
      chk("unused_b_exempt", {31'd0, pc_stall}, 32'd0);
      tick(); id_uses_b = 1;
      @(negedge clk);
      chk("used_b_stall", {31'd0, id_ex_flush}, 32'd1);

      // flag hazard then taken branch
      tick(); idle(); ex_sets_flags = 1; id_br_flags = 1; id_br_taken = 1;
      @(negedge clk);
      chk("flag_bubble", {31'd0, id_ex_flush}, 32'd1);
      chk("flag_no_br_flush", {31'd0, if_id_flush}, 32'd0);
      tick(); ex_sets_flags = 0;
      @(negedge clk);
      chk("br_flush", {31'd0, if_id_flush}, 32'd1);
      chk("br_no_stall", {31'd0, pc_stall}, 32'd0);

      // freeze wins over hazard and branch for three wait states
      tick(); idle(); load_use(4'd7); id_br_taken = 1; mem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("frz_freeze", {31'd0, pipe_freeze}, 32'd1);
         chk("frz_no_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
         tick();
      end
      mem_busy = 0;
      @(negedge clk);
      chk("frz_then_stall", {31'd0, id_ex_flush}, 32'd1);
      chk("frz_then_no_br", {31'd0, if_id_flush}, 32'd0);
      chk("frz_released", {31'd0, pipe_freeze}, 32'd0);

      // halt drain, no wait states: done after edge N+3
      tick(); idle(); id_hlt = 1;
      @(negedge clk);
      chk("hlt_accept", {30'd0, pc_stall, if_id_flush}, 32'd3);
      tick(); id_hlt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hlt_wait", {31'd0, hlt_done}, 32'd0);
         tick();
      end
      @(negedge clk);
      chk("hlt_done_n3", {31'd0, hlt_done}, 32'd1);
      tick(); load_use(4'd2);
      @(negedge clk);
      chk("halted_ignores_hazard", {31'd0, id_ex_flush}, 32'd0);
      chk("halted_hold", {31'd0, hlt_done}, 32'd1);

      // halt drain with one wait state: done after edge N+4
      reset_dut(); id_hlt = 1;
      tick(); id_hlt = 0; mem_busy = 1;
      @(negedge clk);
      chk("drain_busy_freeze", {31'd0, pipe_freeze}, 32'd1);
      tick(); mem_busy = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hlt_busy_wait", {31'd0, hlt_done}, 32'd0);
         tick();
      end
      @(negedge clk);
      chk("hlt_done_n4", {31'd0, hlt_done}, 32'd1);

      // reset mid-drain returns to RUN
      reset_dut(); id_hlt = 1;
      tick(); id_hlt = 0;
      tick(); rst_n = 0; mem_busy = 1;
      @(negedge clk);
      chk("mid_rst_outputs", {26'd0, pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, hlt_done}, 32'd0);
      tick(); rst_n = 1; idle();
      repeat (4) tick();
      @(negedge clk);
      chk("mid_rst_no_done", {31'd0, hlt_done}, 32'd0);
      tick(); load_use(4'd9);
      @(negedge clk);
      chk("mid_rst_run", {31'd0, id_ex_flush}, 32'd1);

      // perf: two load-use stalls and one taken branch
      reset_dut(); load_use(4'd3);
      tick(); idle();
      tick(); load_use(4'd4);
      tick(); idle(); id_br_taken = 1;
      tick(); idle();
      @(negedge clk);
      chk("perf_stall_cycles", stall_cycles, PERF ? 32'd2 : 32'd0);
      chk("perf_flush_count", flush_count, PERF ? 32'd3 : 32'd0);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
